// File: rtl/if_id_pkg.sv
// Shared types and constants for the fetch/decode instruction queue.
package if_id_pkg;

  localparam int unsigned IFQ_DEPTH_DEFAULT = 4;
  localparam int unsigned IFQ_DATA_W        = 32;
  localparam logic [IFQ_DATA_W-1:0] NOP_INSTR = 32'h0;

  typedef struct packed {
    logic [IFQ_DATA_W-1:0] pc;
    logic [IFQ_DATA_W-1:0] instruction;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_storage.sv
// DEPTH-entry register array: one synchronous write port, one asynchronous read port.
// Contents have no reset; validity is tracked by the owner of the pointers.
module ifq_storage
  import if_id_pkg::*;
#(
  parameter int unsigned DEPTH = IFQ_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  ifq_entry_t               wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output ifq_entry_t               rdata
);

  ifq_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction FIFO with flush on taken branch.
// Optional IFQ_BYPASS_EN: an empty queue forwards the fetch pair to decode in the same cycle.
module if_id_queue
  import if_id_pkg::*;
#(
  parameter int unsigned DEPTH  = IFQ_DEPTH_DEFAULT,
  parameter int unsigned DATA_W = IFQ_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_valid,
  input  logic [DATA_W-1:0]        fetch_pc,
  input  logic [DATA_W-1:0]        fetch_instruction,
  output logic                     fetch_ready,
  input  logic                     flush,
  input  logic                     id_ready,
  output logic                     id_valid,
  output logic [DATA_W-1:0]        id_pc,
  output logic [DATA_W-1:0]        id_instruction,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty;
  logic          push_store;
  logic          pop_store;
  ifq_entry_t    wr_entry;
  ifq_entry_t    rd_entry;
`ifdef IFQ_BYPASS_EN
  logic          bypass;
`endif

  ifq_storage #(
    .DEPTH(DEPTH)
  ) u_storage (
    .clk  (clk),
    .we   (push_store),
    .waddr(wr_ptr_q),
    .wdata(wr_entry),
    .raddr(rd_ptr_q),
    .rdata(rd_entry)
  );

  always_comb begin
    empty       = (count_q == '0);
    fetch_ready = (count_q != CW'(DEPTH));
    wr_entry    = '{pc: IFQ_DATA_W'(fetch_pc), instruction: IFQ_DATA_W'(fetch_instruction)};
    pop_store   = ~empty & id_ready & ~flush;
`ifdef IFQ_BYPASS_EN
    bypass      = empty & fetch_valid & ~flush;
    // A bypassed pair consumed by decode this cycle never enters storage.
    push_store  = fetch_valid & fetch_ready & ~flush & ~(bypass & id_ready);
`else
    push_store  = fetch_valid & fetch_ready & ~flush;
`endif

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = pop_store  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      wr_ptr_d = push_store ? wr_ptr_q + AW'(1) : wr_ptr_q;
      count_d  = count_q + CW'(push_store) - CW'(pop_store);
    end
  end

  always_comb begin
    id_valid       = 1'b0;
    id_pc          = '0;
    id_instruction = DATA_W'(NOP_INSTR);
    if (!empty) begin
      id_valid       = 1'b1;
      id_pc          = DATA_W'(rd_entry.pc);
      id_instruction = DATA_W'(rd_entry.instruction);
    end
`ifdef IFQ_BYPASS_EN
    else if (bypass) begin
      id_valid       = 1'b1;
      id_pc          = fetch_pc;
      id_instruction = fetch_instruction;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: a FIFO scoreboard of expected head entries.
module tb_if_id_queue;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 32;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_pc;
  logic [DATA_W-1:0] fetch_instruction;
  logic              fetch_ready;
  logic              flush;
  logic              id_ready;
  logic              id_valid;
  logic [DATA_W-1:0] id_pc;
  logic [DATA_W-1:0] id_instruction;
  logic [$clog2(DEPTH):0] count;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  if_id_queue #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_valid      (fetch_valid),
    .fetch_pc         (fetch_pc),
    .fetch_instruction(fetch_instruction),
    .fetch_ready      (fetch_ready),
    .flush            (flush),
    .id_ready         (id_ready),
    .id_valid         (id_valid),
    .id_pc            (id_pc),
    .id_instruction   (id_instruction),
    .count            (count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, compare outputs mid-cycle, then advance the scoreboard at the edge.
  task automatic step(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                      input logic fl, input logic rdy, input logic rs, input string tag);
    logic        byp;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    logic        do_pop;
    logic        do_push;
    fetch_valid       = fv;
    fetch_pc          = pc;
    fetch_instruction = ins;
    flush             = fl;
    id_ready          = rdy;
    rst               = rs;
    #3;
`ifdef IFQ_BYPASS_EN
    byp = (sb.size() == 0) && fv && !fl;
`else
    byp = 1'b0;
`endif
    if (sb.size() != 0) begin
      e_valid = 1'b1; e_pc = sb[0].pc; e_ins = sb[0].ins;
    end else if (byp) begin
      e_valid = 1'b1; e_pc = pc; e_ins = ins;
    end else begin
      e_valid = 1'b0; e_pc = '0; e_ins = '0;
    end
    chk({tag, ".id_valid"},    64'(id_valid),       64'(e_valid));
    chk({tag, ".id_pc"},       64'(id_pc),          64'(e_pc));
    chk({tag, ".id_instr"},    64'(id_instruction), 64'(e_ins));
    chk({tag, ".count"},       64'(count),          64'(sb.size()));
    chk({tag, ".fetch_ready"}, 64'(fetch_ready),    64'(sb.size() != DEPTH));
    do_pop  = (sb.size() != 0) && rdy;
    do_push = fv && (sb.size() != DEPTH) && !(byp && rdy);
    @(posedge clk);
    if (rs || fl) begin
      sb.delete();
    end else begin
      if (do_pop) void'(sb.pop_front());
      if (do_push) sb.push_back('{pc: pc, ins: ins});
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; fetch_valid = 1'b0; fetch_pc = '0; fetch_instruction = '0;
    flush = 1'b0; id_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    step(0, 32'h0, 32'h0, 0, 0, 0, "reset_idle");

    // Fill with decode stalled, then attempt a fifth push
    for (int unsigned i = 1; i <= 4; i++)
      step(1, 32'(4 * i), 32'hA000_0000 + 32'(i), 0, 0, 0, "fill");
    step(1, 32'd20, 32'hA000_0005, 0, 0, 0, "full_push");
    step(1, 32'd24, 32'hA000_0006, 0, 1, 0, "full_pop_no_push");

    for (int unsigned i = 0; i < 4; i++)
      step(0, 32'h0, 32'h0, 0, 1, 0, "drain");
    step(0, 32'h0, 32'h0, 0, 1, 0, "drained");

    // Two entries in, then ten cycles of simultaneous push/pop to wrap pointers
    step(1, 32'h100, 32'hB000_0000, 0, 0, 0, "wrap_pre");
    step(1, 32'h104, 32'hB000_0001, 0, 0, 0, "wrap_pre");
    for (int unsigned i = 2; i < 12; i++)
      step(1, 32'h100 + 32'(4 * i), 32'hB000_0000 + 32'(i), 0, 1, 0, "wrap");
    step(0, 32'h0, 32'h0, 0, 1, 0, "wrap_drain");
    step(0, 32'h0, 32'h0, 0, 1, 0, "wrap_drain");
    step(0, 32'h0, 32'h0, 0, 1, 0, "wrap_empty");

    // Flush with a concurrent push, then branch target fetch
    for (int unsigned i = 0; i < 3; i++)
      step(1, 32'h10 + 32'(4 * i), 32'hC000_0000 + 32'(i), 0, 0, 0, "flush_pre");
    step(1, 32'h40, 32'hC000_0040, 1, 1, 0, "flush");
    step(1, 32'h80, 32'hC000_0080, 0, 0, 0, "after_flush");
    step(0, 32'h0, 32'h0, 0, 1, 0, "target");
    step(0, 32'h0, 32'h0, 0, 1, 0, "target_empty");

    // Empty queue, fetch and decode both ready
    step(1, 32'h200, 32'hE3A0_1005, 0, 1, 0, "bypass");
    step(0, 32'h0, 32'h0, 0, 1, 0, "bypass_next");
    step(0, 32'h0, 32'h0, 0, 1, 0, "bypass_after");

    // Mid-stream reset drops entries
    step(1, 32'h300, 32'hD000_0000, 0, 0, 0, "rst_pre");
    step(1, 32'h304, 32'hD000_0001, 0, 0, 1, "rst_mid");
    step(0, 32'h0, 32'h0, 0, 0, 0, "rst_after");

    for (int unsigned i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), $urandom, $urandom,
           ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 63) == 0), "rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Instruction queue between the fetch stage and the decode stage of the pipelined core.
- Buffers up to DEPTH {pc, instruction} pairs so that a decode stall does not immediately freeze fetch.
- Discards all buffered entries on a taken branch.
- Its fetch_ready output drives the fetch-stage freeze (freeze = ~fetch_ready).

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- DATA_W, 32, width of the pc and instruction fields.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- fetch_valid  input  1  fetch presents a valid pair this cycle.
- fetch_pc  input  DATA_W  pc value (pc+4) accompanying the instruction.
- fetch_instruction  input  DATA_W  fetched instruction word.
- fetch_ready  output  1  queue accepts a push this cycle.
- flush  input  1  branch taken; discard all entries and the current push.
- id_ready  input  1  decode consumes the head entry this cycle (the inverse of the hazard stall).
- id_valid  output  1  head entry valid.
- id_pc  output  DATA_W  head pc; 0 when id_valid=0.
- id_instruction  output  DATA_W  head instruction; NOP (all zeros) when id_valid=0.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst=1 at a clk edge): rd_ptr=wr_ptr=0, count=0, id_valid=0, id_pc=0, id_instruction=0, fetch_ready=1.
  - Reset has priority over flush, push and pop.
  - Reset asserted mid-stream drops all entries the same as a flush.
- Push = fetch_valid & fetch_ready & ~flush. It writes entry[wr_ptr], and wr_ptr increments modulo DEPTH.
- Pop = id_valid & id_ready & ~flush. rd_ptr increments modulo DEPTH.
- fetch_ready = (count != DEPTH). This is purely combinational from count.
  - No pop-through when full: a full queue refuses a push even if a pop occurs in the same cycle.
- id_valid = (count != 0). id_pc and id_instruction are driven from entry[rd_ptr] and masked to 0 when empty.
- Latency: a pushed pair is visible at the outputs one cycle after the push edge (IFQ_BYPASS_EN undefined).
- Push and pop in the same cycle leave count unchanged; both pointers advance.
- Flush: at the next edge both pointers and count return to 0, and any simultaneous push or pop is ignored.
  - id_valid is 0 in the cycle after flush.
  - A fetch of the branch target in the cycle after flush is accepted normally.
- Pointer wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are distinguished by count only.
- Entries are never overwritten while valid. Storage has no reset; only pointers and count are reset.
- Output order is strictly FIFO with no reordering.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- Defined: when count==0 and fetch_valid & ~flush:
  - id_valid=1 combinationally, and id_pc/id_instruction equal fetch_pc/fetch_instruction in the same cycle.
  - If id_ready=1 as well, the pair is consumed and not stored (count stays 0).
  - If id_ready=0, it is stored as a normal push.
- Undefined: no combinational path from the fetch inputs to the id outputs; minimum latency is 1 cycle.

Decomposition:
- Package if_id_pkg holds:
  - IFQ_DEPTH_DEFAULT=4;
  - NOP_INSTR=32'h0;
  - typedef ifq_entry_t {pc, instruction}.
- Sub-module ifq_storage holds the DEPTH x ifq_entry_t register array:
  - one write port (we, waddr, wdata);
  - one asynchronous read port (raddr, rdata).
- if_id_queue keeps the pointers, count, flush and bypass logic.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> count=0, id_valid=0, id_instruction=0, fetch_ready=1.
- Fill, stalled decode: id_ready=0, push pc=4,8,12,16 with instr A1..A4.
  - -> count=4 and fetch_ready=0 after the 4th edge.
  - A 5th fetch_valid is not stored; id_pc stays 4 and id_instruction=A1.
- Drain in order: from full, id_ready=1 and fetch_valid=0 -> outputs A1,A2,A3,A4 on consecutive cycles, then id_valid=0 and count=0.
- Wrap with simultaneous push/pop: 10 cycles with fetch_valid=1 and id_ready=1 starting at count=2.
  - -> count stays 2 and the pointers wrap past DEPTH.
  - Output sequence equals the input sequence delayed by 2 entries.
- Flush with concurrent push: count=3, flush=1, fetch_valid=1 (pc=0x40).
  - -> next cycle count=0 and id_valid=0, and 0x40 is absent.
  - A push of pc=0x80 in the following cycle appears at id_pc one cycle later.
- IFQ_BYPASS_EN, empty queue: fetch_valid=1, id_ready=1, instr=0xE3A01005.
  - -> id_valid=1 and id_instruction=0xE3A01005 in the same cycle, count stays 0.
  - Without the macro: id_valid=0 that cycle, then id_valid=1 next cycle.
